// File: rtl/i2c_target_regs.sv
// I2C target that exposes an 8-bit register pointer / data strobe port to
// fabric logic. SCL and SDA are oversampled on clk100. The block never
// stretches the clock. Every output comes straight from a flop.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk100,
    input  logic       sys_rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ACK_ADDR  = 4'd2,
        ST_PTR       = 4'd3,
        ST_ACK_PTR   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_ACK_WDATA = 4'd6,
        ST_RDATA     = 4'd7,
        ST_MACK      = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // Filter counter value on which a pending line change is accepted.
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    // Input conditioning
    logic       scl_meta_r;
    logic       scl_sync_r;
    logic       sda_meta_r;
    logic       sda_sync_r;
    logic       scl_filt_r;
    logic       sda_filt_r;
    logic [3:0] scl_cnt_r;
    logic [3:0] sda_cnt_r;
    logic       scl_prev_r;
    logic       sda_prev_r;

    // Bus events derived from the filtered lines
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       sda_rise_s;
    logic       sda_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] rx_byte_s;
    logic       last_bit_s;

    // Control state
    state_t     state_r;
    state_t     state_nxt_s;

    // Datapath registers and their next values
    logic       sda_oe_r;
    logic       busy_r;
    logic [7:0] reg_addr_r;
    logic [7:0] reg_wdata_r;
    logic       reg_we_r;
    logic       reg_re_r;
    logic       re_d_r;
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       rw_r;
    logic       mack_ok_r;

    logic       sda_oe_nxt_s;
    logic       busy_nxt_s;
    logic [7:0] reg_addr_nxt_s;
    logic [7:0] reg_wdata_nxt_s;
    logic       reg_we_nxt_s;
    logic       reg_re_nxt_s;
    logic       re_d_nxt_s;
    logic [7:0] shift_nxt_s;
    logic [2:0] bit_cnt_nxt_s;
    logic       rw_nxt_s;
    logic       mack_ok_nxt_s;

    // Two-flop synchronizers on the raw bus lines (idle-high)
    always_ff @(posedge clk100) begin
        if (!sys_rst_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Glitch filters: a line follows its input only after FILTER_LEN differing samples in a row
    always_ff @(posedge clk100) begin
        if (!sys_rst_n) begin
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_cnt_r  <= 4'd0;
            sda_cnt_r  <= 4'd0;
        end else begin
            if (scl_sync_r == scl_filt_r) begin
                scl_cnt_r <= 4'd0;
            end else if (scl_cnt_r == FILT_LAST) begin
                scl_filt_r <= scl_sync_r;
                scl_cnt_r  <= 4'd0;
            end else begin
                scl_cnt_r <= scl_cnt_r + 4'd1;
            end
            if (sda_sync_r == sda_filt_r) begin
                sda_cnt_r <= 4'd0;
            end else if (sda_cnt_r == FILT_LAST) begin
                sda_filt_r <= sda_sync_r;
                sda_cnt_r  <= 4'd0;
            end else begin
                sda_cnt_r <= sda_cnt_r + 4'd1;
            end
        end
    end

    // Previous filtered levels, used for edge detection
    always_ff @(posedge clk100) begin
        if (!sys_rst_n) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_filt_r;
            sda_prev_r <= sda_filt_r;
        end
    end

    assign scl_rise_s = scl_filt_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_filt_r & scl_prev_r;
    assign sda_rise_s = sda_filt_r & ~sda_prev_r;
    assign sda_fall_s = ~sda_filt_r & sda_prev_r;
    // START/STOP need SCL high both before and after the SDA edge, so an SDA
    // edge coinciding with an SCL edge is never taken as a bus condition.
    assign start_s    = sda_fall_s & scl_filt_r & scl_prev_r;
    assign stop_s     = sda_rise_s & scl_filt_r & scl_prev_r;
    assign rx_byte_s  = {shift_r[6:0], sda_filt_r};
    assign last_bit_s = (bit_cnt_r == 3'd7);

    // Control state register
    always_ff @(posedge clk100) begin
        if (!sys_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; START and STOP override any bit activity
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ST_ADDR;
        end else if (stop_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ADDR: begin
                    if (scl_rise_s && last_bit_s) begin
                        if (shift_r[6:0] == DEV_ADDR) begin
                            state_nxt_s = ST_ACK_ADDR;
                        end else begin
                            state_nxt_s = ST_IGNORE;
                        end
                    end else begin
                        state_nxt_s = ST_ADDR;
                    end
                end
                ST_ACK_ADDR: begin
                    // Second SCL fall in this state ends the ACK clock
                    if (scl_fall_s && sda_oe_r) begin
                        state_nxt_s = rw_r ? ST_RDATA : ST_PTR;
                    end else begin
                        state_nxt_s = ST_ACK_ADDR;
                    end
                end
                ST_PTR: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_nxt_s = ST_ACK_PTR;
                    end else begin
                        state_nxt_s = ST_PTR;
                    end
                end
                ST_ACK_PTR: begin
                    if (scl_fall_s && sda_oe_r) begin
                        state_nxt_s = ST_WDATA;
                    end else begin
                        state_nxt_s = ST_ACK_PTR;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise_s && last_bit_s) begin
                        state_nxt_s = ST_ACK_WDATA;
                    end else begin
                        state_nxt_s = ST_WDATA;
                    end
                end
                ST_ACK_WDATA: begin
                    if (scl_fall_s && sda_oe_r) begin
                        state_nxt_s = ST_WDATA;
                    end else begin
                        state_nxt_s = ST_ACK_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (!re_d_r && scl_fall_s && last_bit_s) begin
                        state_nxt_s = ST_MACK;
                    end else begin
                        state_nxt_s = ST_RDATA;
                    end
                end
                ST_MACK: begin
                    if (scl_rise_s && sda_filt_r) begin
                        state_nxt_s = ST_IGNORE;
                    end else if (scl_fall_s && mack_ok_r) begin
                        state_nxt_s = ST_RDATA;
                    end else begin
                        state_nxt_s = ST_MACK;
                    end
                end
                ST_IGNORE: begin
                    state_nxt_s = ST_IGNORE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values for the current state and bus events
    always_comb begin
        sda_oe_nxt_s    = sda_oe_r;
        busy_nxt_s      = busy_r;
        reg_addr_nxt_s  = reg_addr_r;
        reg_wdata_nxt_s = reg_wdata_r;
        reg_we_nxt_s    = 1'b0;
        reg_re_nxt_s    = 1'b0;
        re_d_nxt_s      = reg_re_r;
        shift_nxt_s     = shift_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        rw_nxt_s        = rw_r;
        mack_ok_nxt_s   = mack_ok_r;

        // The pointer advances the cycle after a write strobe
        if (reg_we_r) begin
            reg_addr_nxt_s = reg_addr_r + 8'd1;
        end else begin
            reg_addr_nxt_s = reg_addr_r;
        end

        if (start_s) begin
            busy_nxt_s    = 1'b1;
            sda_oe_nxt_s  = 1'b0;
            bit_cnt_nxt_s = 3'd0;
            re_d_nxt_s    = 1'b0;
        end else if (stop_s) begin
            busy_nxt_s    = 1'b0;
            sda_oe_nxt_s  = 1'b0;
            bit_cnt_nxt_s = 3'd0;
            re_d_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = rx_byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        if (last_bit_s) begin
                            case (state_r)
                                ST_ADDR: begin
                                    rw_nxt_s = sda_filt_r;
                                end
                                ST_PTR: begin
                                    reg_addr_nxt_s = rx_byte_s;
                                end
                                ST_WDATA: begin
                                    reg_wdata_nxt_s = rx_byte_s;
                                    reg_we_nxt_s    = 1'b1;
                                end
                                default: begin
                                    rw_nxt_s = rw_r;
                                end
                            endcase
                        end else begin
                            rw_nxt_s = rw_r;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WDATA: begin
                    // First fall starts driving the ACK, second fall releases it
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_nxt_s = 1'b1;
                        end else begin
                            sda_oe_nxt_s  = 1'b0;
                            bit_cnt_nxt_s = 3'd0;
                            reg_re_nxt_s  = (state_r == ST_ACK_ADDR) && rw_r;
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_RDATA: begin
                    // The first bit cannot go out before the fetched byte is back,
                    // so it is driven as soon as reg_rdata is captured.
                    if (re_d_r) begin
                        shift_nxt_s  = reg_rdata;
                        sda_oe_nxt_s = ~reg_rdata[7];
                    end else if (scl_fall_s) begin
                        if (last_bit_s) begin
                            sda_oe_nxt_s   = 1'b0;
                            reg_addr_nxt_s = reg_addr_r + 8'd1;
                            bit_cnt_nxt_s  = 3'd0;
                            mack_ok_nxt_s  = 1'b0;
                        end else begin
                            shift_nxt_s   = {shift_r[6:0], 1'b0};
                            sda_oe_nxt_s  = ~shift_r[6];
                            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        sda_oe_nxt_s = sda_oe_r;
                    end
                end
                ST_MACK: begin
                    if (scl_rise_s) begin
                        mack_ok_nxt_s = ~sda_filt_r;
                    end else if (scl_fall_s && mack_ok_r) begin
                        reg_re_nxt_s  = 1'b1;
                        bit_cnt_nxt_s = 3'd0;
                        mack_ok_nxt_s = 1'b0;
                    end else begin
                        mack_ok_nxt_s = mack_ok_r;
                    end
                end
                default: begin
                    // IDLE and IGNORE never drive the bus
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk100) begin
        if (!sys_rst_n) begin
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            re_d_r      <= 1'b0;
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            rw_r        <= 1'b0;
            mack_ok_r   <= 1'b0;
        end else begin
            sda_oe_r    <= sda_oe_nxt_s;
            busy_r      <= busy_nxt_s;
            reg_addr_r  <= reg_addr_nxt_s;
            reg_wdata_r <= reg_wdata_nxt_s;
            reg_we_r    <= reg_we_nxt_s;
            reg_re_r    <= reg_re_nxt_s;
            re_d_r      <= re_d_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            rw_r        <= rw_nxt_s;
            mack_ok_r   <= mack_ok_nxt_s;
        end
    end

    assign sda_oe    = sda_oe_r;
    assign busy      = busy_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign reg_re    = reg_re_r;

endmodule
